// File: rtl/wavegen_top.sv
// Programmable-rate waveform generator: a divisor-driven tick advances an
// 8-bit phase, which is shaped into sawtooth/triangle/square/inverse-saw.
module wavegen_top #(
  parameter int unsigned DIV_W = 10,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             start,
  input  logic [DIV_W-1:0] SW,
  input  logic             mode,
  input  logic             sel,
  output logic [OUT_W-1:0] out
);

  typedef enum logic {
    STOPPED,
    RUNNING
  } state_t;

  state_t state, state_next;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic [OUT_W-1:0] phase;
  logic [OUT_W-1:0] shape;
  logic             running;
  logic             tick;

  // Control: init stops the generator and dominates start.
  always_ff @(posedge clk) begin
    if (!rst) state <= STOPPED;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (init)       state_next = STOPPED;
    else if (start) state_next = RUNNING;
  end

  assign running = (state == RUNNING);
  assign tick    = running && (cnt == '1);

  // Datapath: counter reloads from div on each tick, so the tick period is
  // 2**DIV_W - div cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div   <= '0;
      cnt   <= '0;
      phase <= '0;
      out   <= '0;
    end else begin
      if (init) begin
        div   <= SW;
        cnt   <= SW;
        phase <= '0;
      end else if (running) begin
        if (tick) begin
          cnt   <= div;
          phase <= phase + 1'b1;
        end else begin
          cnt   <= cnt + 1'b1;
        end
      end
      out <= shape;
    end
  end

  always_comb begin
    shape = phase;
    case ({sel, mode})
      2'b00: shape = phase;
      2'b01: shape = phase[OUT_W-1] ? ~{phase[OUT_W-2:0], 1'b0}
                                    :  {phase[OUT_W-2:0], 1'b0};
      2'b10: shape = phase[OUT_W-1] ? '1 : '0;
      2'b11: shape = ~phase;
      default: shape = phase;
    endcase
  end

endmodule

// File: tb/tb_wavegen_top.sv
// Self-checking bench for wavegen_top: closed-form expected samples are queued
// before each edge and compared against out just after it.
module tb_wavegen_top;

  logic       clk;
  logic       rst;
  logic       init;
  logic       start;
  logic [9:0] SW;
  logic       mode;
  logic       sel;
  logic [7:0] out;

  int checks;
  int failures;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  wavegen_top #(.DIV_W(10), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .init(init), .start(start),
    .SW(SW), .mode(mode), .sel(sel), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference waveshape, written arithmetically from the shape definitions.
  function automatic logic [7:0] ref_shape(input logic [1:0] sm, input logic [7:0] p);
    int v;
    case (sm)
      2'b00: v = p;
      2'b01: v = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      2'b10: v = (p >= 128) ? 255 : 0;
      default: v = 255 - p;
    endcase
    return 8'(v);
  endfunction

  // Phase seen by out at the n-th edge after the start edge, period per tick.
  function automatic logic [7:0] ref_phase(input int n, input int period);
    return 8'((n - 1) / period);
  endfunction

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [9:0] sw);
    init = 1'b1;
    SW   = sw;
    edge1();
    init = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    edge1();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    init  = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
    SW    = 10'($urandom);
    mode  = 1'($urandom_range(0, 1));
    sel   = 1'($urandom_range(0, 1));
    exp_q.push_back(8'h00);
    edge1();
    exp_v = exp_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL reset_out got=%02h exp=%02h", out, exp_v);
    end
    rst = 1'b1; init = 1'b0; start = 1'b0; mode = 1'b0; sel = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      exp_q.push_back(8'h00);
      edge1();
      exp_v = exp_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL idle_after_reset n=%0d got=%02h exp=%02h", n, out, exp_v);
      end
    end
  endtask

  task automatic test_slow_rate;
    sel = 1'b0; mode = 1'b0;
    do_init(10'd0);
    do_start();
    for (int n = 1; n <= 10000; n++) begin
      exp_q.push_back(ref_shape(2'b00, ref_phase(n, 1024)));
      edge1();
      exp_v = exp_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL slow_rate n=%0d got=%02h exp=%02h", n, out, exp_v);
      end
      // Divisor switches without init must not change the step spacing.
      if (n == 3000) SW = 10'b1001101101;
    end
  endtask

  task automatic test_fast_wrap;
    sel = 1'b0; mode = 1'b0;
    do_init(10'd1023);
    do_start();
    for (int n = 1; n <= 600; n++) begin
      exp_q.push_back(ref_shape(2'b00, ref_phase(n, 1)));
      edge1();
      exp_v = exp_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL fast_wrap n=%0d got=%02h exp=%02h", n, out, exp_v);
      end
    end
  endtask

  task automatic test_shapes;
    logic [1:0] sm;
    sm = 2'b01;
    {sel, mode} = sm;
    do_init(10'd1020);
    do_start();
    for (int n = 1; n <= 1100; n++) begin
      exp_q.push_back(ref_shape(sm, ref_phase(n, 4)));
      edge1();
      exp_v = exp_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL shape sm=%0d n=%0d got=%02h exp=%02h", sm, n, out, exp_v);
      end
      if (n % 37 == 0) begin
        sm = sm + 2'd1;
        {sel, mode} = sm;
      end
    end
  endtask

  task automatic test_init_start_same;
    sel = 1'b0; mode = 1'b0;
    init = 1'b1; start = 1'b1; SW = 10'd1020;
    edge1();
    init = 1'b0; start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      exp_q.push_back(8'h00);
      edge1();
      exp_v = exp_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL init_start_same n=%0d got=%02h exp=%02h", n, out, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    sel = 1'b0; mode = 1'b0;
    do_init(10'd1020);
    do_start();
    for (int n = 1; n <= 80; n++) begin
      exp_q.push_back(ref_shape(2'b00, ref_phase(n, 4)));
      edge1();
      exp_v = exp_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL second_start n=%0d got=%02h exp=%02h", n, out, exp_v);
      end
      if (n == 30) start = 1'b1;
      if (n == 31) start = 1'b0;
    end
  endtask

  task automatic test_init_mid_run;
    sel = 1'b0; mode = 1'b0;
    do_init(10'd1020);
    do_start();
    for (int n = 1; n <= 100; n++) begin
      exp_q.push_back((n <= 61) ? ref_shape(2'b00, ref_phase(n, 4)) : 8'h00);
      edge1();
      exp_v = exp_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL init_mid_run n=%0d got=%02h exp=%02h", n, out, exp_v);
      end
      if (n == 60) init = 1'b1;
      if (n == 61) init = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run;
    sel = 1'b0; mode = 1'b0;
    do_init(10'd1020);
    do_start();
    for (int n = 1; n <= 40; n++) begin
      exp_q.push_back(ref_shape(2'b00, ref_phase(n, 4)));
      edge1();
      exp_v = exp_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL pre_reset_run n=%0d got=%02h exp=%02h", n, out, exp_v);
      end
    end
    rst = 1'b0;
    exp_q.push_back(8'h00);
    edge1();
    rst = 1'b1;
    exp_v = exp_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL mid_reset_out got=%02h exp=%02h", out, exp_v);
    end
    do_start();
    for (int n = 1; n <= 2100; n++) begin
      exp_q.push_back(ref_shape(2'b00, ref_phase(n, 1024)));
      edge1();
      exp_v = exp_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL post_reset_rate n=%0d got=%02h exp=%02h", n, out, exp_v);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; init = 1'b0; start = 1'b0; SW = '0; mode = 1'b0; sel = 1'b0;
    #2;
    test_reset();
    test_slow_rate();
    test_fast_wrap();
    test_shapes();
    test_init_start_same();
    test_back_to_back();
    test_init_mid_run();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wavegen_top.md
Name: wavegen_top

Overview:
Programmable-rate 8-bit digital waveform generator for the lab board. A 10-bit divisor captured from the switches sets the step rate of an 8-bit phase counter. sel and mode pick one of four waveshapes derived from that phase. out drives the 8-bit DAC/LED bank.

Parameters:
DIV_W, 10, divisor/tick-counter width (ports fixed at SW[9:0])
OUT_W, 8, phase and output width (ports fixed at out[7:0])

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset
init  input  1  level; load divisor from SW, clear phase, stop generator
start  input  1  pulse/level; start generator
SW  input  10  divisor value, sampled only while init=1
mode  input  1  waveshape select, low bit
sel  input  1  waveshape select, high bit
out  output  8  registered waveform sample

Behaviour:
Clock and reset:
- One clock, clk. rst is synchronous, active-low.
- rst=0 at a rising edge: DIV=0, cnt=0, phase=0, running=0, out=0.
- rst has priority over all other inputs.

Priority when rst=1: init > start.

init=1 at an edge:
- DIV <= SW, cnt <= SW.
- phase <= 0, running <= 0.
- Any start asserted in the same cycle is ignored.

start=1 (init=0) at an edge:
- running <= 1.
- If already running: no effect; no restart, no phase clear.
- There is no stop input. Only init or rst stops the generator.

Tick generator:
- tick = running & (cnt == 1023), combinational.
- While running, each edge: if tick then cnt <= DIV, else cnt <= cnt+1.
- While not running, cnt holds.
- Tick period = 1024-DIV cycles.
- DIV=1023 gives a tick every cycle; DIV=0 gives a tick every 1024 cycles.
- After a start edge, the first tick occurs on the (1024-DIV)-th following edge.
- SW changes without init have no effect.

Phase:
- On each tick, phase <= phase+1, 8-bit, wraps 255 -> 0.

Output (registered):
- out is updated every edge, including while stopped, from the current phase register.
- This gives one cycle of latency after the phase changes.
- {sel,mode}=00 sawtooth: out = phase.
- {sel,mode}=01 triangle: out = phase[7] ? ~{phase[6:0],0} : {phase[6:0],0}.
- {sel,mode}=10 square: out = phase[7] ? 8'hFF : 8'h00.
- {sel,mode}=11 inverse sawtooth: out = ~phase.
- Changing sel/mode mid-run: out reflects the new shape at the next edge; phase is unaffected.
- After init with phase=0: out is 00 (modes 00/01/10) or FF (mode 11) one edge later.

Implementation:
- Separate datapath (DIV, cnt, phase, out registers) and control (running flag, tick decode).
- No latches. No combinational path from inputs to out.

Test Plan:
- Reset: hold rst=0 for 1 edge with random other inputs -> out=00. Release; with no init/start, out stays 00 for 2000 cycles.
- Slow rate: init=1 with SW=0, then start pulse, sel=mode=0 -> out becomes 01 exactly 1025 edges after the start edge. out is 09 at 10000 cycles. SW changed to 10'b1001101101 afterwards without init does not alter the 1024-cycle step spacing.
- Fast rate and wrap: init with SW=1023, start, mode 00 -> out increments every cycle; after 256 steps out goes FF -> 00.
- Shapes: init with SW=1020 (period 4), start, then step through {sel,mode}:
  - 01: phase 64 -> out 80; phase 127 -> FE; phase 128 -> FF; phase 255 -> 01.
  - 10: out 00 for phase<128, FF for phase>=128.
  - 11: phase 0 -> FF.
- Control corners:
  - init and start high in the same cycle -> running stays 0, out stays 00.
  - A second start while running leaves phase unchanged.
  - init mid-run -> phase=0; out 00 next edge; no further steps until start.
- Reset mid-operation: rst=0 for one edge while running at DIV=1020 -> out=00 and DIV=0. After release with start only, steps occur every 1024 cycles.
